// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, credit-limited in-order imem requests, PC-tagged buffer to decode.
// Zero-wait memory gives id_valid two cycles after the grant; requests stall when buffer+in-flight reach FIFO_DEPTH.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = AW + 2;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc;
  logic [CW-1:0]   outstanding, out_nxt, fifo_count;
  logic [AW-1:0]   tag_wr, tag_rd, buf_wr, buf_rd;
  logic [31:0]     tag_mem   [FIFO_DEPTH];
  logic [31:0]     buf_instr [FIFO_DEPTH];
  logic [31:0]     buf_pc    [FIFO_DEPTH];
  logic [SW-1:0]   credit_sum;
  logic            credit_ok, fire, rsp_acc, push, pop;

  assign pop        = id_valid & id_ready;
  assign credit_sum = SW'(fifo_count) + SW'(outstanding) - SW'(pop);
  assign credit_ok  = credit_sum < SW'(FIFO_DEPTH);
  assign fire       = imem_req & imem_gnt;
  // Responses with nothing in flight are protocol errors and are ignored outright.
  assign rsp_acc    = imem_rvalid & (outstanding != '0);
  assign push       = rsp_acc & (state == RUN) & ~redirect_valid;
  assign out_nxt    = outstanding + CW'(fire) - CW'(rsp_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (redirect_valid && out_nxt != '0) state_nxt = DRAIN;
      DRAIN:   if (out_nxt == '0) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    imem_req = ~rst & (state == RUN) & credit_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      fifo_count  <= '0;
    end else begin
      if (redirect_valid) pc <= redirect_pc & ~32'd3;
      else if (fire)      pc <= pc + 32'd4;
      outstanding <= out_nxt;
      // Tag queue is never flushed: dropped responses still retire their tags in order.
      if (fire)    tag_wr <= tag_wr + AW'(1);
      if (rsp_acc) tag_rd <= tag_rd + AW'(1);
      if (redirect_valid) begin
        buf_wr     <= '0;
        buf_rd     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) buf_wr <= buf_wr + AW'(1);
        if (pop)  buf_rd <= buf_rd + AW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) tag_mem[tag_wr] <= pc;
    if (push) begin
      buf_instr[buf_wr] <= imem_rdata;
      buf_pc[buf_wr]    <= tag_mem[tag_rd];
    end
  end

  assign imem_addr = pc;
  assign id_valid  = (fifo_count != '0);
  assign id_instr  = id_valid ? buf_instr[buf_rd] : 32'd0;
  assign id_pc     = id_valid ? buf_pc[buf_rd]    : 32'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory responder with fixed latency, scoreboard on the decode side.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;

  fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } rsp_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  rsp_t        pending[$];
  exp_t        exp_q[$];
  int          pop_cyc[$];
  logic [31:0] grant_log[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          gnt_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = p ^ 32'hA5A5_0000;
    exp_q.push_back(e);
  endtask

  // Let test-driven inputs settle, then grant against the combinational request.
  task automatic settle();
    #1;
    imem_gnt = gnt_en & imem_req;
    if (imem_gnt) begin
      pending.push_back('{due: cyc + lat, data: imem_addr ^ 32'hA5A5_0000});
      grant_log.push_back(imem_addr);
    end
  endtask

  task automatic tick();
    rsp_t r;
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    imem_gnt = 1'b0;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      r = pending.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = r.data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
    end
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'd0;
    imem_gnt = 1'b0;
    redirect_valid = 1'b0;
    pending.delete();
    grant_log.delete();
    pop_cyc.delete();
    cyc = 0;
  endtask

  // Scoreboard monitor: every decode transfer must match the oldest expected fetch.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got pc %h, expected no transfer (cycle %0d)", id_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e.pc);
        chk("id_instr", id_instr, e.instr);
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] t2_grants [4];
    t2_grants = '{32'h0, 32'h4, 32'h8, 32'hC};
    #1;
    do_reset();

    // 1: streaming at one instruction per cycle
    id_ready = 1'b1; gnt_en = 1'b1; lat = 1;
    for (int k = 0; k < 8; k++) expect_fetch(32'(k * 4));
    for (int k = 0; k < 12; k++) begin
      if (k == 8) gnt_en = 1'b0;
      settle();
      if (k < 8) chk("t1_addr", imem_addr, 32'(k * 4));
      if (k == 1) chk("t1_valid_c1", 32'(id_valid), 32'd0);
      if (k == 2) begin
        chk("t1_valid_c2", 32'(id_valid), 32'd1);
        chk("t1_pc_c2", id_pc, 32'h0);
      end
      tick();
    end
    chk("t1_grants", 32'(grant_log.size()), 32'd8);
    chk("t1_pops", 32'(pop_cyc.size()), 32'd8);
    for (int i = 0; i < pop_cyc.size(); i++) chk("t1_pop_cycle", 32'(pop_cyc[i]), 32'(i + 2));

    // 2: decode stalled -> credit limit, then drain and resume
    do_reset();
    id_ready = 1'b0; gnt_en = 1'b1; lat = 1;
    expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8); expect_fetch(32'hC);
    expect_fetch(32'h10);
    for (int k = 0; k < 8; k++) cycle();
    settle();
    chk("t2_req_full", 32'(imem_req), 32'd0);
    tick();
    chk("t2_grants", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("t2_grant_addr", grant_log[i], t2_grants[i]);
    id_ready = 1'b1;
    settle();
    chk("t2_resume_req", 32'(imem_req), 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h10);
    tick();
    gnt_en = 1'b0;
    for (int k = 0; k < 8; k++) cycle();
    chk("t2_grants_total", 32'(grant_log.size()), 32'd5);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3: redirect with two responses in flight -> both dropped
    do_reset();
    id_ready = 1'b1; gnt_en = 1'b1; lat = 3;
    cycle(); cycle();
    gnt_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    settle();
    chk("t3_valid_c2", 32'(id_valid), 32'd0);
    tick();
    settle();
    chk("t3_req_c3", 32'(imem_req), 32'd0);
    chk("t3_rvalid_c3", 32'(imem_rvalid), 32'd1);
    tick();
    settle();
    chk("t3_req_c4", 32'(imem_req), 32'd0);
    chk("t3_valid_c4", 32'(id_valid), 32'd0);
    tick();
    settle();
    chk("t3_req_c5", 32'(imem_req), 32'd1);
    chk("t3_addr_c5", imem_addr, 32'h100);
    chk("t3_valid_c5", 32'(id_valid), 32'd0);
    tick();

    // 4: redirect with nothing outstanding, low bits forced to zero
    do_reset();
    lat = 1; gnt_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    settle();
    tick();
    settle();
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h100);
    tick();

    // 5: grant withheld -> request held, address stable
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t5_req_held", 32'(imem_req), 32'd1);
      chk("t5_addr_held", imem_addr, 32'h100);
      tick();
    end
    gnt_en = 1'b1;
    expect_fetch(32'h100);
    settle();
    tick();
    gnt_en = 1'b0;
    settle();
    chk("t5_addr_adv", imem_addr, 32'h104);
    tick();
    for (int k = 0; k < 3; k++) cycle();
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // PC wraps from the top of the address space to zero
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    settle();
    tick();
    gnt_en = 1'b1;
    expect_fetch(32'hFFFF_FFFC);
    settle();
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    gnt_en = 1'b0;
    settle();
    chk("wrap_addr_zero", imem_addr, 32'h0);
    tick();
    for (int k = 0; k < 3; k++) cycle();
    chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

    // 6: reset with a full buffer, then a stray response
    do_reset();
    id_ready = 1'b0; gnt_en = 1'b1; lat = 1;
    for (int k = 0; k < 8; k++) cycle();
    gnt_en = 1'b0;
    settle();
    chk("t6_full_valid", 32'(id_valid), 32'd1);
    chk("t6_full_req", 32'(imem_req), 32'd0);
    #1;
    do_reset();
    settle();
    chk("t6_first_req", 32'(imem_req), 32'd1);
    chk("t6_first_addr", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    settle();
    tick();
    settle();
    chk("t6_stray_valid", 32'(id_valid), 32'd0);
    chk("t6_stray_req", 32'(imem_req), 32'd1);
    chk("t6_stray_addr", imem_addr, 32'h0);
    tick();

    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
